// File: rtl/game_timer.sv
// Game countdown timer driven by the wrap of the down-counting clock divider.
// Each divider wrap (counter == 0) becomes a registered one-second tick that
// decrements a two-digit BCD value. The game-control FSM gets a single
// time_up pulse when the value reaches 00.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; digits 00, waiting for start
// RUN   | counting down one BCD step per tick
// PAUSE | digits frozen, ticks ignored until pause or start
// DONE  | reached 00; holds until start reloads
module game_timer #(
   parameter int WARN_SECS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [27:0] counter,
   input  logic        start,
   input  logic        pause,
   input  logic [3:0]  start_tens,
   input  logic [3:0]  start_ones,
   output logic        tick,
   output logic [3:0]  tens,
   output logic [3:0]  ones,
   output logic [1:0]  state,
   output logic        warning,
   output logic        time_up
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   localparam logic [6:0] WARN_LIMIT = 7'(WARN_SECS);

   logic [1:0] state_nxt;
   logic [3:0] tens_nxt;
   logic [3:0] ones_nxt;
   logic       time_up_nxt;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic [6:0] secs;

   // Out-of-range BCD digits from the start switches are treated as 9.
   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign load_tens = clamp_bcd(start_tens);
   assign load_ones = clamp_bcd(start_ones);

   // One-second tick: registered detect of the divider wrap, active in every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick <= 1'b0;
      end else begin
         tick <= (counter == 28'd0);
      end
   end

   // State and digit registers, including the registered time_up pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         tens    <= 4'd0;
         ones    <= 4'd0;
         time_up <= 1'b0;
      end else begin
         state   <= state_nxt;
         tens    <= tens_nxt;
         ones    <= ones_nxt;
         time_up <= time_up_nxt;
      end
   end

   // Next-state and next-digit logic; start beats pause beats tick.
   always_comb begin
      state_nxt   = state;
      tens_nxt    = tens;
      ones_nxt    = ones;
      time_up_nxt = 1'b0;

      if (start) begin
         // A load of 00 skips RUN so 00 is never seen while counting.
         tens_nxt = load_tens;
         ones_nxt = load_ones;
         if (load_tens == 4'd0 && load_ones == 4'd0) begin
            state_nxt   = ST_DONE;
            time_up_nxt = 1'b1;
         end else begin
            state_nxt = ST_RUN;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (pause) begin
                  state_nxt = ST_PAUSE;
               end else if (tick) begin
                  if (ones != 4'd0) begin
                     ones_nxt = ones - 4'd1;
                  end else begin
                     ones_nxt = 4'd9;
                     tens_nxt = tens - 4'd1;
                  end
                  if (tens_nxt == 4'd0 && ones_nxt == 4'd0) begin
                     state_nxt   = ST_DONE;
                     time_up_nxt = 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (pause) begin
                  state_nxt = ST_RUN;
               end
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   // Low-time warning, only while the timer is active.
   always_comb begin
      secs    = 7'(tens) * 7'd10 + 7'(ones);
      warning = ((state == ST_RUN) || (state == ST_PAUSE)) && (secs <= WARN_LIMIT);
   end

endmodule
